// File: rtl/vector_mem_responder_if.sv
// vector_mem_responder_if: memory-stage bus; master=datapath drives MemWriteM/MemReadM/AddrM/writeDataM, slave=responder drives RDM/StallM/BusyM
interface vector_mem_responder_if #(parameter int N = 16);
  logic                MemWriteM;
  logic                MemReadM;
  logic [31:0]         AddrM;
  logic [15:0][N-1:0]  writeDataM;
  logic [15:0][N-1:0]  RDM;
  logic                StallM;
  logic                BusyM;
  modport master (output MemWriteM, MemReadM, AddrM, writeDataM, input RDM, StallM, BusyM);
  modport slave  (input MemWriteM, MemReadM, AddrM, writeDataM, output RDM, StallM, BusyM);
endinterface

// File: rtl/vector_mem_responder.sv
// vector_mem_responder: serves 16-lane vector load/store lane by lane on a single-ported store; ports CLK, RST (async high), m (slave bus: strobes/addr/wdata in, RDM/StallM/BusyM out)
module vector_mem_responder #(
  parameter int N     = 16,
  parameter int DEPTH = 1024
) (
  input logic                   CLK,
  input logic                   RST,
  vector_mem_responder_if.slave m
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t              state;
  logic [3:0]          cnt;
  logic [AW-1:0]       base;
  logic [AW-1:0]       addr;
  logic [15:0][N-1:0]  wbuf;
  logic [15:0][N-1:0]  rdm;
  logic                busy;
  logic [N-1:0]        mem [DEPTH];
  logic                unused_addr;
  assign unused_addr = ^m.AddrM[31:AW];
  assign addr = base + AW'(cnt);
  assign m.RDM = rdm;
  assign m.BusyM = busy;
  assign m.StallM = (state == IDLE) ? (m.MemWriteM | m.MemReadM) : (state == READ || state == WRITE);
  always_ff @(posedge CLK)
    if (state == WRITE) mem[addr] <= wbuf[cnt];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      wbuf  <= '0;
      rdm   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m.MemWriteM) begin
            base  <= m.AddrM[AW-1:0];
            wbuf  <= m.writeDataM;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= WRITE;
          end else if (m.MemReadM) begin
            base  <= m.AddrM[AW-1:0];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ, WRITE: begin
          if (state == READ) rdm[cnt] <= mem[addr];
          cnt <= cnt + 4'd1;
          if (&cnt) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
